fifo_stream_reader: RTL and testbench

- Drain side of the capture FIFO: generates single-cycle pop strobes, samples the FIFO output word one cycle later, and presents each word on a valid/ready stream toward the frame transfer logic.
- A burst starts when the FIFO reports full or on an explicit flush, and runs until the FIFO reports its last word popped.
- Marks the final word with out_last and reports the burst word count.

---
 rtl/fifo_reader_pkg.sv | 14 +
 rtl/stream_out_reg.sv | 44 ++++
 rtl/fifo_stream_reader.sv | 134 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared encoding for the capture-FIFO drain state machine.
package fifo_reader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_POP     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the reader stream: captures a word and its
// last flag on load, keeps them stable until the downstream handshake.
//
// Handshake: a word transfers on the rising edge where o_valid && i_ready.
// o_valid stays high and data/last stay stable until that edge; the
// upstream never drops a presented word.
module stream_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_last;
  logic                  r_valid;

  // Load a new word, or retire the current one on handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last && r_valid;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain side of the capture FIFO. Issues one pop strobe per word, samples
// the FIFO output buffer the cycle after the pop, and presents each word on
// a valid/ready stream. A burst starts on FIFO full or a latched flush and
// ends once the FIFO reports its last word popped (or FIFO_SIZE pops).
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_SIZE   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   flush,
  input  logic                   fifo_ready,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  input  logic                   fifo_popped_last,
  input  logic                   fifo_pushed_last,
  output logic                   fifo_pop,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   burst_done,
  output logic [COUNT_WIDTH-1:0] words_read,
  output logic                   sync_error
);

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_flush_pending;
  logic                   r_burst_done;
  logic                   r_sync_error;
  logic [COUNT_WIDTH-1:0] r_words_read;

  logic w_go;
  logic w_start;
  logic w_empty_flush;
  logic w_at_limit;
  logic w_load;
  logic w_handshake;
  logic w_out_valid;
  logic w_out_last;

  assign w_go          = enable && fifo_ready;
  assign w_start       = w_go && !fifo_popped_last && (fifo_pushed_last || r_flush_pending);
  // A flush that finds the FIFO already empty completes without popping.
  assign w_empty_flush = r_flush_pending && fifo_popped_last;
  assign w_at_limit    = (r_words_read == COUNT_WIDTH'(FIFO_SIZE));
  assign w_load        = (r_state == ST_CAPTURE);
  assign w_handshake   = w_out_valid && out_ready;

  // Next-state selection; the word in OUTPUT always finishes its handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_POP;
      ST_POP:     w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_OUTPUT;
      ST_OUTPUT: begin
        if (w_handshake) begin
          if (w_out_last) w_next = ST_IDLE;
          else if (w_go)  w_next = ST_POP;
          else            w_next = ST_PAUSE;
        end
      end
      ST_PAUSE:   if (w_go) w_next = ST_POP;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Flush latch: only meaningful in IDLE, dropped as soon as it is consumed.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)                          r_flush_pending <= 1'b0;
    else if (r_state != ST_IDLE)        r_flush_pending <= 1'b0;
    else if (w_start || w_empty_flush)  r_flush_pending <= 1'b0;
    else if (flush)                     r_flush_pending <= 1'b1;
  end

  // Burst word counter, cleared at burst start, saturating on pop.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_words_read <= '0;
    end else if (r_state == ST_IDLE && (w_start || w_empty_flush)) begin
      r_words_read <= '0;
    end else if (r_state == ST_POP && r_words_read != '1) begin
      r_words_read <= r_words_read + COUNT_WIDTH'(1);
    end
  end

  // End-of-burst pulse and sticky FIFO desynchronisation flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_burst_done <= 1'b0;
      r_sync_error <= 1'b0;
    end else begin
      r_burst_done <= (r_state == ST_IDLE && w_empty_flush) ||
                      (r_state == ST_OUTPUT && w_handshake && w_out_last);
      if (r_state == ST_CAPTURE && w_at_limit && !fifo_popped_last)
        r_sync_error <= 1'b1;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out (
    .i_clk   (clock),
    .i_rst   (clear),
    .i_load  (w_load),
    .i_data  (fifo_data),
    .i_last  (fifo_popped_last || w_at_limit),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (w_out_valid),
    .o_last  (w_out_last)
  );

  assign fifo_pop   = (r_state == ST_POP);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = w_out_valid;
  assign out_last   = w_out_last;
  assign burst_done = r_burst_done;
  assign words_read = r_words_read;
  assign sync_error = r_sync_error;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader,
// a scoreboard holds the words the stream must deliver.
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int FS = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          enable, flush, fifo_ready, out_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_popped_last, fifo_pushed_last;
  logic          fifo_pop, out_valid, out_last, busy, burst_done, sync_error;
  logic [DW-1:0] out_data;
  logic [CW-1:0] words_read;

  fifo_stream_reader #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .clear(clear), .enable(enable), .flush(flush),
    .fifo_ready(fifo_ready), .fifo_data(fifo_data),
    .fifo_popped_last(fifo_popped_last), .fifo_pushed_last(fifo_pushed_last),
    .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .burst_done(burst_done), .words_read(words_read), .sync_error(sync_error)
  );

  // clock / reset
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // FIFO model and scoreboard
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  bit never_last = 0;
  bit pop_pending = 0, prev_pop = 0, prev_go = 0;
  bit exp_sync = 0, done_next = 0, in_burst = 0, done_seen = 0;
  bit flush_req = 0, eflush_arm = 0;
  int eflush_cnt = 0, exp_count = 0, burst_pops = 0, hs_cnt = 0;
  int burst_cyc = 0, first_pop = -1, first_valid = -1, done_cyc = -1, done_words = -1;
  logic [DW-1:0] last_data = '0;
  int ready_pct = 100, enable_pct = 100, fready_pct = 100, mflush_pct = 0;
  int stall_at = -1, stall_left = 0, en_off_after = 0, en_off_len = 0, en_off_left = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic update_fifo_flags();
    fifo_popped_last = never_last ? 1'b0 : (fifo_q.size() == 0);
    fifo_pushed_last = (fifo_q.size() == FS);
  endtask

  task automatic fill_fifo(input int n, input bit seq, input logic [DW-1:0] base);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(seq ? base + DW'(i) : DW'($urandom()));
    burst_pops = 0; hs_cnt = 0; in_burst = 1; done_seen = 0;
    burst_cyc = 0; first_pop = -1; first_valid = -1; done_cyc = -1; done_words = -1;
    update_fifo_flags();
  endtask

  // One clock: apply FIFO pop, compare every output, then drive new inputs.
  task automatic step();
    bit exp_done_now;
    bit hs;
    @(posedge clock); #1;
    burst_cyc++;
    if (pop_pending) begin
      if (fifo_q.size() == 0) begin
        if (!never_last) check("pop_when_empty", 1, 0);
      end else begin
        fifo_data = fifo_q.pop_front();
      end
      burst_pops++;
      exp_q.push_back(fifo_data);
      exp_last_q.push_back((!never_last && fifo_q.size() == 0) || burst_pops == FS);
      if (burst_pops == FS && (never_last || fifo_q.size() != 0)) exp_sync = 1;
    end
    update_fifo_flags();

    exp_done_now = done_next;
    done_next = 0;
    if (eflush_cnt > 0) begin
      eflush_cnt--;
      if (eflush_cnt == 0) exp_done_now = 1;
    end
    check("burst_done", burst_done, exp_done_now);
    if (burst_done) begin
      done_seen = 1; done_cyc = burst_cyc; done_words = int'(words_read);
      check("done_words", words_read, exp_count);
      check("idle_after_done", busy, 0);
      in_burst = 0;
    end
    if (fifo_pop) begin
      check("pop_gap", prev_pop, 0);
      check("pop_gated", prev_go, 1);
      check("pop_in_burst", in_burst, 1);
      check("pop_while_valid", out_valid, 0);
      if (first_pop < 0) first_pop = burst_cyc;
    end
    if (out_valid) begin
      if (first_valid < 0) first_valid = burst_cyc;
      check("valid_has_word", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("out_data", out_data, exp_q[0]);
        check("out_last", out_last, exp_last_q[0]);
      end
      check("sync_error", sync_error, exp_sync);
      if (out_last) last_data = out_data;
    end else begin
      check("last_unqualified", out_last, 0);
    end

    // driver
    out_ready = int'($urandom_range(0, 99)) < ready_pct;
    if (stall_left > 0 && out_valid && hs_cnt == stall_at) begin
      out_ready = 1'b0;
      stall_left--;
    end
    hs = out_valid && out_ready;
    if (hs) begin
      hs_cnt++;
      if (hs_cnt == en_off_after) en_off_left = en_off_len;
      if (exp_q.size() != 0) begin
        if (exp_last_q[0]) begin
          done_next = 1;
          exp_count = burst_pops;
        end
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
      end
    end
    enable = int'($urandom_range(0, 99)) < enable_pct;
    if (en_off_left > 0) begin
      enable = 1'b0;
      en_off_left--;
    end
    fifo_ready = int'($urandom_range(0, 99)) < fready_pct;
    flush = flush_req || (in_burst && int'($urandom_range(0, 99)) < mflush_pct);
    if (flush_req && eflush_arm) begin
      eflush_cnt = 2;
      exp_count = 0;
    end
    flush_req = 0; eflush_arm = 0;
    prev_pop = fifo_pop; prev_go = enable && fifo_ready; pop_pending = fifo_pop;
  endtask

  task automatic run_burst(input int n, input bit use_flush, input bit seq, input logic [DW-1:0] base);
    fill_fifo(n, seq, base);
    if (use_flush) flush_req = 1;
    for (int c = 0; c < 2000 && !done_seen; c++) step();
    check("burst_timeout", done_seen, 1);
    check("fifo_drained", fifo_q.size(), 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1; #1;
    check("rst_pop", fifo_pop, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", burst_done, 0);
    check("rst_sync", sync_error, 0);
    check("rst_data", out_data, 0);
    check("rst_words", words_read, 0);
    exp_q.delete(); exp_last_q.delete(); fifo_q.delete();
    pop_pending = 0; prev_pop = 0; done_next = 0; eflush_cnt = 0;
    exp_sync = 0; in_burst = 0; never_last = 0;
    update_fifo_flags();
    step(); step();
    clear = 1'b0;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    enable = 1'b1; flush = 1'b0; fifo_ready = 1'b1; out_ready = 1'b1; fifo_data = '0;
    update_fifo_flags();
    #3;
    do_clear();

    // full FIFO, free-flowing stream
    run_burst(8, 0, 1, 32'h10);
    check("t1_first_pop", first_pop, 1);
    check("t1_first_valid", first_valid, 3);
    check("t1_done_cyc", done_cyc, 25);
    check("t1_words", done_words, 8);
    check("t1_last_word", last_data, 32'h17);
    check("t1_sync", sync_error, 0);
    idle(3);

    // partial FIFO drained by flush
    run_burst(3, 1, 1, 32'hA0);
    check("t2_first_pop", first_pop, 3);
    check("t2_done_cyc", done_cyc, 12);
    check("t2_words", done_words, 3);
    check("t2_last_word", last_data, 32'hA2);
    idle(2);

    // flush with an empty FIFO
    done_seen = 0; eflush_arm = 1; flush_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_busy", busy, 0);
      check("t3_no_pop", fifo_pop, 0);
    end
    check("t3_done_seen", done_seen, 1);
    idle(2);

    // downstream stall on the second word
    stall_at = 1; stall_left = 5;
    run_burst(8, 0, 1, 32'h20);
    check("t4_done_cyc", done_cyc, 30);
    check("t4_stall_used", stall_left, 0);
    stall_at = -1;
    idle(2);

    // enable low for 4 cycles after the first handshake
    en_off_after = 1; en_off_len = 4;
    run_burst(8, 0, 1, 32'h60);
    check("t5_done_cyc", done_cyc, 29);
    check("t5_words", done_words, 8);
    en_off_after = 0;
    idle(2);

    // full and flush together while enable is held off: one burst only
    en_off_left = 3; step();
    run_burst(8, 1, 1, 32'h70);
    check("t6_first_pop", first_pop, 4);
    check("t6_words", done_words, 8);
    idle(4);

    // clear while a word sits in OUTPUT, then a fresh burst
    fill_fifo(8, 1, 32'h30);
    for (int g = 0; g < 100 && !(hs_cnt >= 2 && out_valid); g++) step();
    check("t7_in_output", out_valid, 1);
    do_clear();
    run_burst(8, 0, 1, 32'h40);
    check("t7_first_pop", first_pop, 1);
    check("t7_words", done_words, 8);
    idle(2);

    // FIFO that never reports its last word
    never_last = 1;
    run_burst(8, 0, 1, 32'h50);
    check("t8_words", done_words, 8);
    check("t8_last_word", last_data, 32'h57);
    idle(3);
    check("t8_sync_sticky", sync_error, 1);
    do_clear();
    check("t8_sync_cleared", sync_error, 0);

    // randomized bursts with backpressure, gating and stray flushes
    for (int b = 0; b < 30; b++) begin
      int n;
      n = int'($urandom_range(1, 8));
      ready_pct  = int'($urandom_range(30, 100));
      enable_pct = int'($urandom_range(50, 100));
      fready_pct = int'($urandom_range(60, 100));
      mflush_pct = 10;
      run_burst(n, (n < 8) || ($urandom_range(0, 1) == 1), 0, '0);
      check("rnd_words", done_words, n);
      mflush_pct = 0;
      idle(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
